// File: rtl/router_pkt_ingress_if.sv
// router_pkt_ingress_if: source word stream, per-destination FIFO handshake and status pulses
interface router_pkt_ingress_if #(
  parameter int DATA_W = 8,
  parameter int N_DEST = 3
);
  logic [DATA_W-1:0] data_in;
  logic pkt_vld;
  logic [N_DEST-1:0] fifo_full;
  logic [N_DEST-1:0] wr_en;
  logic [DATA_W-1:0] data_out;
  logic busy;
  logic error;
  logic drop;
  logic pkt_done;
  modport master(output data_in, pkt_vld, fifo_full, input wr_en, data_out, busy, error, drop, pkt_done);
  modport slave(input data_in, pkt_vld, fifo_full, output wr_en, data_out, busy, error, drop, pkt_done);
endinterface

// File: rtl/router_pkt_ingress.sv
// router_pkt_ingress: parses header/payload/parity packets and routes each word to one of N_DEST FIFOs
module router_pkt_ingress #(
  parameter int DATA_W = 8,
  parameter int N_DEST = 3,
  parameter int ADDR_W = 2
) (
  input logic clock,
  input logic resetn,
  router_pkt_ingress_if.slave bus
);
  localparam int LEN_W = DATA_W - ADDR_W;
  typedef enum logic [2:0] {IDLE, PAYLOAD, PARITY, HOLD, DROP} state_t;
  // A word waiting to be written, tagged with its destination and parity outcome
  typedef struct packed {
    logic vld;
    logic last;
    logic bad;
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] word;
  } ent_t;
  state_t state, state_nx, parse_nx, saved;
  ent_t p, h, cur, nent;
  logic [LEN_W-1:0] cnt, hdr_len;
  logic [DATA_W-1:0] par;
  logic [ADDR_W-1:0] addr, hdr_addr;
  logic accept, hdr_ok, full_sel, wr, stall, drop_q;
  assign hdr_addr = bus.data_in[ADDR_W-1:0];
  assign hdr_len = bus.data_in[DATA_W-1:ADDR_W];
  assign hdr_ok = 32'(hdr_addr) < N_DEST;
  assign accept = bus.pkt_vld && state != HOLD;
  // State register
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  // Packet parsing, write/stall decision and output strobes
  always_comb begin
    parse_nx = state;
    case (state)
      IDLE: parse_nx = !accept ? IDLE : !hdr_ok ? DROP : hdr_len != '0 ? PAYLOAD : PARITY;
      PAYLOAD: parse_nx = accept && cnt == LEN_W'(1) ? PARITY : PAYLOAD;
      PARITY: parse_nx = accept ? IDLE : PARITY;
      DROP: parse_nx = accept && cnt == '0 ? IDLE : DROP;
      default: parse_nx = state;
    endcase
    cur = state == HOLD ? h : p;
    full_sel = |(bus.fifo_full & (N_DEST'(1) << cur.dst));
    wr = cur.vld && !full_sel;
    stall = state != HOLD && p.vld && full_sel;
    state_nx = state == HOLD ? (wr ? saved : HOLD) : stall ? HOLD : parse_nx;
    nent.vld = accept && (state == PAYLOAD || state == PARITY || (state == IDLE && hdr_ok));
    nent.last = state == PARITY;
    nent.bad = par != bus.data_in;
    nent.dst = state == IDLE ? hdr_addr : addr;
    nent.word = bus.data_in;
    bus.wr_en = wr ? N_DEST'(1) << cur.dst : '0;
    bus.data_out = wr ? cur.word : '0;
    bus.busy = state == HOLD;
    bus.error = wr && cur.last && cur.bad;
    bus.drop = drop_q;
    bus.pkt_done = (wr && cur.last) || drop_q;
  end
  // Length counter, running parity, and the pending/holding write entries
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      p <= '0;
      h <= '0;
      saved <= IDLE;
      cnt <= '0;
      par <= '0;
      addr <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= accept && state == DROP && cnt == '0;
      if (state != HOLD) p <= nent;
      if (stall) begin
        h <= p;
        saved <= parse_nx;
      end else if (state == HOLD && wr) h.vld <= 1'b0;
      if (accept && state == IDLE) begin
        addr <= hdr_addr;
        cnt <= hdr_len;
        par <= bus.data_in;
      end else if (accept && (state == PAYLOAD || (state == DROP && cnt != '0))) begin
        cnt <= cnt - LEN_W'(1);
        par <= par ^ bus.data_in;
      end
    end
endmodule
